// File: rtl/mpt2042_spi_slave.sv
// SPI mode-3 slave bridging byte frames onto a simple register bus.
// First byte is the command (R/W + start address); following bytes are data.
module mpt2042_spi_slave #(
    parameter int unsigned ADDR_INC = 1,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_clk,
    input  logic       spi_ssn,
    input  logic       spi_si,
    output logic       spi_so,
    output logic       spi_so_oe,
    output logic       reg_wr_vld,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdat,
    output logic       reg_rd_req,
    input  logic [7:0] reg_rdat,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] byte_cnt
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t              state;
    logic [SYNC_STG-1:0] clk_sync;
    logic [SYNC_STG-1:0] ssn_sync;
    logic [SYNC_STG-1:0] si_sync;
    logic                clk_d;
    logic                ssn_d;
    logic [SW-1:0]       settle_cnt;
    logic                ready;
    logic [SW-1:0]       bit_cnt;
    logic [DW-1:0]       rx_sr;
    logic [DW-1:0]       tx_sr;
    logic [AW-1:0]       addr;
    logic                rd_pend;

    logic          clk_s_c;
    logic          ssn_s_c;
    logic          si_s_c;
    logic          clk_rise_c;
    logic          clk_fall_c;
    logic          ssn_rise_c;
    logic          ssn_fall_c;
    logic [DW-1:0] rx_byte_c;
    logic [AW-1:0] addr_nxt_c;

    // Input synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            clk_sync   <= '1;
            ssn_sync   <= '1;
            si_sync    <= '0;
            clk_d      <= 1'b1;
            ssn_d      <= 1'b1;
            settle_cnt <= '0;
            ready      <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STG-2:0], spi_clk};
            ssn_sync <= {ssn_sync[SYNC_STG-2:0], spi_ssn};
            si_sync  <= {si_sync[SYNC_STG-2:0], spi_si};
            clk_d    <= clk_sync[SYNC_STG-1];
            ssn_d    <= ssn_sync[SYNC_STG-1];
            // Edges are masked until the chain holds only real pin samples,
            // so a select held low across reset is not mistaken for a fall.
            if (!ready) begin
                settle_cnt <= settle_cnt + SW'(1);
                ready      <= (settle_cnt == SW'(SYNC_STG));
            end
        end
    end

    always_comb begin
        clk_s_c    = clk_sync[SYNC_STG-1];
        ssn_s_c    = ssn_sync[SYNC_STG-1];
        si_s_c     = si_sync[SYNC_STG-1];
        clk_rise_c = ready &  clk_s_c & ~clk_d;
        clk_fall_c = ready & ~clk_s_c &  clk_d;
        ssn_rise_c = ready &  ssn_s_c & ~ssn_d;
        ssn_fall_c = ready & ~ssn_s_c &  ssn_d;
        rx_byte_c  = {rx_sr[DW-2:0], si_s_c};
        addr_nxt_c = (ADDR_INC != 0) ? addr + AW'(1) : addr;
    end

    // Frame FSM, shift registers and register-bus strobes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            addr       <= '0;
            rd_pend    <= 1'b0;
            spi_so     <= 1'b0;
            spi_so_oe  <= 1'b0;
            reg_wr_vld <= 1'b0;
            reg_addr   <= '0;
            reg_wdat   <= '0;
            reg_rd_req <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            reg_wr_vld <= 1'b0;
            reg_rd_req <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_pend    <= reg_rd_req;
            spi_so_oe  <= ~ssn_s_c;
            spi_so     <= (state == RDATA && !ssn_s_c) ? tx_sr[DW-1] : 1'b0;
            if (rd_pend) begin
                tx_sr <= reg_rdat;
            end

            case (state)
                IDLE: begin
                    if (ssn_fall_c) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        rx_sr    <= '0;
                        byte_cnt <= '0;
                    end
                end
                default: begin
                    if (ssn_rise_c) begin
                        frame_done <= (bit_cnt == '0);
                        frame_err  <= (bit_cnt != '0);
                        bit_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        // MSB is already on the pin at the first falling edge of a byte.
                        if (clk_fall_c && state == RDATA && bit_cnt != '0) begin
                            tx_sr <= {tx_sr[DW-2:0], 1'b0};
                        end
                        if (clk_rise_c) begin
                            rx_sr   <= rx_byte_c;
                            bit_cnt <= bit_cnt + SW'(1);
                            if (bit_cnt == SW'(7)) begin
                                if (byte_cnt != 8'hFF) begin
                                    byte_cnt <= byte_cnt + 8'd1;
                                end
                                case (state)
                                    CMD: begin
                                        addr <= rx_byte_c[AW-1:0];
                                        if (rx_byte_c[DW-1]) begin
                                            state      <= RDATA;
                                            reg_rd_req <= 1'b1;
                                            reg_addr   <= rx_byte_c[AW-1:0];
                                        end else begin
                                            state <= WDATA;
                                        end
                                    end
                                    WDATA: begin
                                        reg_wr_vld <= 1'b1;
                                        reg_addr   <= addr;
                                        reg_wdat   <= rx_byte_c;
                                        addr       <= addr_nxt_c;
                                    end
                                    default: begin
                                        addr       <= addr_nxt_c;
                                        reg_rd_req <= 1'b1;
                                        reg_addr   <= addr_nxt_c;
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpt2042_spi_slave.sv
// Bench for mpt2042_spi_slave: SPI master model, register responder and
// write/read scoreboards; a second instance runs with a fixed address.
module tb_mpt2042_spi_slave;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_ssn = 1'b1;
    logic       spi_si  = 1'b0;

    logic       spi_so, spi_so_oe, reg_wr_vld, reg_rd_req, frame_done, frame_err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdat, byte_cnt;
    logic [7:0] reg_rdat = 8'h00;

    logic       spi_so_f, spi_so_oe_f, reg_wr_vld_f, reg_rd_req_f, frame_done_f, frame_err_f;
    logic [6:0] reg_addr_f;
    logic [7:0] reg_wdat_f, byte_cnt_f;
    logic [7:0] reg_rdat_f = 8'h00;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    wr_t        exp_wr_f[$];
    logic [6:0] exp_rd[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    logic chk_fixed = 1'b0;

    mpt2042_spi_slave #(.ADDR_INC(1), .SYNC_STG(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_clk(spi_clk), .spi_ssn(spi_ssn),
        .spi_si(spi_si), .spi_so(spi_so), .spi_so_oe(spi_so_oe), .reg_wr_vld(reg_wr_vld),
        .reg_addr(reg_addr), .reg_wdat(reg_wdat), .reg_rd_req(reg_rd_req), .reg_rdat(reg_rdat),
        .frame_done(frame_done), .frame_err(frame_err), .byte_cnt(byte_cnt)
    );

    mpt2042_spi_slave #(.ADDR_INC(0), .SYNC_STG(3)) dut_fixed (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_clk(spi_clk), .spi_ssn(spi_ssn),
        .spi_si(spi_si), .spi_so(spi_so_f), .spi_so_oe(spi_so_oe_f), .reg_wr_vld(reg_wr_vld_f),
        .reg_addr(reg_addr_f), .reg_wdat(reg_wdat_f), .reg_rd_req(reg_rd_req_f), .reg_rdat(reg_rdat_f),
        .frame_done(frame_done_f), .frame_err(frame_err_f), .byte_cnt(byte_cnt_f)
    );

    always #5 sys_clk = ~sys_clk;

    // Register file model: read data is addr ^ 0x3C, valid one cycle after the request.
    always @(posedge sys_clk) begin
        if (reg_rd_req)   reg_rdat   <= {1'b0, reg_addr} ^ 8'h3C;
        if (reg_rd_req_f) reg_rdat_f <= {1'b0, reg_addr_f} ^ 8'h3C;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Advance n cycles; pop the scoreboards whenever the DUT emits a strobe.
    task automatic step(input int n);
        wr_t        e;
        logic [6:0] ea;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            if (reg_wr_vld) begin
                n_checks++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL wr_strobe: got addr=%h data=%h, required no write", reg_addr, reg_wdat);
                end else begin
                    e = exp_wr.pop_front();
                    if ({reg_addr, reg_wdat} !== e)
                        $display("FAIL wr_strobe: got addr=%h data=%h, required addr=%h data=%h",
                                 reg_addr, reg_wdat, e.a, e.d);
                    else n_pass++;
                end
            end
            if (reg_rd_req) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL rd_req: got addr=%h, required no request", reg_addr);
                end else begin
                    ea = exp_rd.pop_front();
                    if (reg_addr !== ea) $display("FAIL rd_req: got addr=%h, required addr=%h", reg_addr, ea);
                    else n_pass++;
                end
            end
            if (chk_fixed && reg_wr_vld_f) begin
                n_checks++;
                if (exp_wr_f.size() == 0) begin
                    $display("FAIL wr_fixed: got addr=%h data=%h, required no write", reg_addr_f, reg_wdat_f);
                end else begin
                    e = exp_wr_f.pop_front();
                    if ({reg_addr_f, reg_wdat_f} !== e)
                        $display("FAIL wr_fixed: got addr=%h data=%h, required addr=%h data=%h",
                                 reg_addr_f, reg_wdat_f, e.a, e.d);
                    else n_pass++;
                end
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
        end
    endtask

    // Mode-3 master: drive on falling edge, sample on rising edge, 8 sys_clk per half period.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_clk = 1'b0;
            spi_si  = tx[i];
            step(8);
            spi_clk = 1'b1;
            rx[i]   = spi_so;
            step(8);
        end
    endtask

    task automatic select();
        spi_ssn = 1'b0;
        step(8);
    endtask

    task automatic deselect();
        spi_ssn = 1'b1;
        step(12);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(3);
        n_checks++;
        if ({spi_so, spi_so_oe, reg_wr_vld, reg_addr, reg_wdat, reg_rd_req, frame_done, frame_err, byte_cnt} !== 29'd0)
            $display("FAIL reset_outputs: got %h, required 0", {spi_so, spi_so_oe, reg_wr_vld, reg_addr,
                     reg_wdat, reg_rd_req, frame_done, frame_err, byte_cnt});
        else n_pass++;
        n_checks++;
        if ({spi_so_f, spi_so_oe_f, reg_wr_vld_f, reg_addr_f, reg_wdat_f, reg_rd_req_f, frame_done_f,
             frame_err_f, byte_cnt_f} !== 29'd0)
            $display("FAIL reset_outputs_fixed: got nonzero, required 0");
        else n_pass++;
        sys_rst = 1'b0;
        step(10);
    endtask

    task automatic test_write();
        logic [7:0] r0, r1, r2;
        int d0 = done_cnt, e0 = err_cnt;
        exp_wr.push_back('{a: 7'h05, d: 8'hA1});
        exp_wr.push_back('{a: 7'h06, d: 8'hB2});
        select();
        n_checks++;
        if (spi_so_oe !== 1'b1) $display("FAIL write_oe: got %b, required 1", spi_so_oe);
        else n_pass++;
        spi_xfer(8'h05, 8, r0);
        spi_xfer(8'hA1, 8, r1);
        spi_xfer(8'hB2, 8, r2);
        deselect();
        n_checks++;
        if ((r0 | r1 | r2) !== 8'h00) $display("FAIL write_so_zero: got %h, required 00", r0 | r1 | r2);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0)
            $display("FAIL write_frame_end: got done=%0d err=%0d, required done=1 err=0", done_cnt - d0, err_cnt - e0);
        else n_pass++;
        n_checks++;
        if (byte_cnt !== 8'd3) $display("FAIL write_byte_cnt: got %0d, required 3", byte_cnt);
        else n_pass++;
        n_checks++;
        if (spi_so_oe !== 1'b0 || exp_wr.size() != 0)
            $display("FAIL write_end: got oe=%b pending=%0d, required oe=0 pending=0", spi_so_oe, exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_read();
        logic [7:0] r0, r1, r2;
        exp_rd.push_back(7'h05);
        exp_rd.push_back(7'h06);
        exp_rd.push_back(7'h07);
        select();
        spi_xfer(8'h85, 8, r0);
        spi_xfer(8'h00, 8, r1);
        spi_xfer(8'h00, 8, r2);
        deselect();
        n_checks++;
        if (r1 !== 8'h39) $display("FAIL read_byte0: got %h, required 39", r1);
        else n_pass++;
        n_checks++;
        if (r2 !== 8'h3A) $display("FAIL read_byte1: got %h, required 3a", r2);
        else n_pass++;
        n_checks++;
        if (exp_rd.size() != 0 || byte_cnt !== 8'd3)
            $display("FAIL read_end: got pending=%0d byte_cnt=%0d, required 0 and 3", exp_rd.size(), byte_cnt);
        else n_pass++;
    endtask

    task automatic test_addr_wrap();
        logic [7:0] r;
        chk_fixed = 1'b1;
        exp_wr.push_back('{a: 7'h7F, d: 8'h11});
        exp_wr.push_back('{a: 7'h00, d: 8'h22});
        exp_wr_f.push_back('{a: 7'h7F, d: 8'h11});
        exp_wr_f.push_back('{a: 7'h7F, d: 8'h22});
        select();
        spi_xfer(8'h7F, 8, r);
        spi_xfer(8'h11, 8, r);
        spi_xfer(8'h22, 8, r);
        deselect();
        chk_fixed = 1'b0;
        n_checks++;
        if (exp_wr.size() != 0 || exp_wr_f.size() != 0)
            $display("FAIL wrap_pending: got inc=%0d fixed=%0d, required 0 0", exp_wr.size(), exp_wr_f.size());
        else n_pass++;
    endtask

    task automatic test_partial();
        logic [7:0] r;
        int d0 = done_cnt, e0 = err_cnt;
        select();
        spi_xfer(8'h05, 8, r);
        spi_xfer(8'hE7, 3, r);
        deselect();
        n_checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0)
            $display("FAIL partial_frame_end: got err=%0d done=%0d, required err=1 done=0", err_cnt - e0, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (byte_cnt !== 8'd1 || spi_so_oe !== 1'b0)
            $display("FAIL partial_state: got byte_cnt=%0d oe=%b, required 1 0", byte_cnt, spi_so_oe);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        int d0, e0;
        select();
        spi_xfer(8'h20, 8, r);
        spi_xfer(8'hC3, 4, r);
        sys_rst = 1'b1;
        step(3);
        n_checks++;
        if (byte_cnt !== 8'd0 || reg_wr_vld !== 1'b0)
            $display("FAIL midreset_outputs: got byte_cnt=%0d wr=%b, required 0 0", byte_cnt, reg_wr_vld);
        else n_pass++;
        sys_rst = 1'b0;
        step(10);
        // Select still low after release: clocked bits must not open a frame.
        d0 = done_cnt;
        e0 = err_cnt;
        spi_xfer(8'h85, 8, r);
        spi_ssn = 1'b1;
        step(12);
        n_checks++;
        if (done_cnt != d0 || err_cnt != e0 || byte_cnt !== 8'd0)
            $display("FAIL midreset_no_frame: got done=%0d err=%0d byte_cnt=%0d, required 0 0 0",
                     done_cnt - d0, err_cnt - e0, byte_cnt);
        else n_pass++;
        exp_wr.push_back('{a: 7'h10, d: 8'h55});
        select();
        spi_xfer(8'h10, 8, r);
        spi_xfer(8'h55, 8, r);
        deselect();
        n_checks++;
        if (exp_wr.size() != 0 || byte_cnt !== 8'd2 || done_cnt - d0 != 1)
            $display("FAIL midreset_new_frame: got pending=%0d byte_cnt=%0d done=%0d, required 0 2 1",
                     exp_wr.size(), byte_cnt, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_idle_clk();
        logic [7:0] bc = byte_cnt;
        int d0 = done_cnt, e0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            spi_clk = ~spi_clk;
            spi_si  = 1'($urandom_range(0, 1));
            step(8);
        end
        n_checks++;
        if (spi_so_oe !== 1'b0 || byte_cnt !== bc || done_cnt != d0 || err_cnt != e0)
            $display("FAIL idle_clk: got oe=%b byte_cnt=%0d done=%0d err=%0d, required 0 %0d 0 0",
                     spi_so_oe, byte_cnt, done_cnt - d0, err_cnt - e0, bc);
        else n_pass++;
    endtask

    task automatic test_empty_frame();
        int d0 = done_cnt, e0 = err_cnt;
        select();
        deselect();
        n_checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || byte_cnt !== 8'd0)
            $display("FAIL empty_frame: got done=%0d err=%0d byte_cnt=%0d, required 1 0 0",
                     done_cnt - d0, err_cnt - e0, byte_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [7:0] r;
        int d0 = done_cnt;
        select();
        spi_xfer(8'h00, 8, r);
        for (int i = 0; i < 256; i++) begin
            exp_wr.push_back('{a: 7'(i), d: 8'(i)});
            spi_xfer(8'(i), 8, r);
        end
        deselect();
        n_checks++;
        if (byte_cnt !== 8'd255 || exp_wr.size() != 0 || done_cnt - d0 != 1)
            $display("FAIL saturation: got byte_cnt=%0d pending=%0d done=%0d, required 255 0 1",
                     byte_cnt, exp_wr.size(), done_cnt - d0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_wrap();
        test_partial();
        test_reset_mid();
        test_idle_clk();
        test_empty_frame();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpt2042_spi_slave.md
MPT2042_SPI_SLAVE -- requirements
Module: mpt2042_spi_slave

Interface
REQ-001 Parameter: ADDR_INC, 1, auto-increment register address after each data byte (0 = fixed address).
REQ-002 Parameter: SYNC_STG, 2, synchronizer depth on spi_clk/spi_ssn/spi_si (legal 2..3).
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 spi_clk  in  1  SPI clock from master, idles high (CPOL=1, CPHA=1).
REQ-006 spi_ssn  in  1  slave select, active-low.
REQ-007 spi_si  in  1  master-to-slave data, MSB first.
REQ-008 spi_so  out  1  slave-to-master data, MSB first.
REQ-009 spi_so_oe  out  1  output enable for spi_so pad, high while selected.
REQ-010 reg_wr_vld  out  1  one-cycle write strobe.
REQ-011 reg_addr  out  7  register address for write strobe or read request.
REQ-012 reg_wdat  out  8  write data, valid with reg_wr_vld.
REQ-013 reg_rd_req  out  1  one-cycle read request.
REQ-014 reg_rdat  in  8  read data, valid exactly 1 cycle after reg_rd_req.
REQ-015 frame_done  out  1  one-cycle pulse, frame ended on byte boundary.
REQ-016 frame_err  out  1  one-cycle pulse, frame ended mid-byte.
REQ-017 byte_cnt  out  8  complete bytes in current/last frame, saturates at 255.

Function
REQ-018 spi_clk, spi_ssn, spi_si shall pass through SYNC_STG flops; edges detected from synchronized copies (1 extra cycle).
REQ-019 Legal operation shall require spi_clk half-period >= 8 sys_clk cycles; faster clocks are out of scope.
REQ-020 FSM states: IDLE, CMD, WDATA, RDATA; IDLE->CMD on synchronized ssn fall.
REQ-021 Bits shall be sampled on synchronized spi_clk rising edge into an 8-bit shift register; a 3-bit counter wraps 7->0 per byte.
REQ-022 Command byte: bit7 = R/W (1 = read), bits6:0 = start address; CMD->RDATA if bit7=1, else CMD->WDATA.
REQ-023 On command-byte completion with read: reg_rd_req pulses with reg_addr = command address in the next cycle.
REQ-024 reg_rdat shall be loaded into the tx shift register the cycle after reg_rd_req; MSB on spi_so before the first falling edge of the next byte.
REQ-025 In RDATA, tx register shifts left on each synchronized spi_clk falling edge; at each byte completion address advances (if ADDR_INC) and next reg_rd_req issues.
REQ-026 In WDATA, at each byte completion reg_wr_vld pulses one cycle with reg_addr = current address, reg_wdat = received byte; address then advances (if ADDR_INC).
REQ-027 Address increment shall wrap 7'h7F -> 7'h00.
REQ-028 During CMD and WDATA spi_so shall drive 0.
REQ-029 spi_so_oe = inverted synchronized spi_ssn; spi_so = 0 when spi_so_oe = 0.
REQ-030 byte_cnt clears on ssn fall, increments at each byte completion including command byte, holds after frame end.
REQ-031 On synchronized ssn rise with bit counter = 0: frame_done pulse, go IDLE; with bit counter != 0: frame_err pulse, partial byte discarded (no strobe), go IDLE.
REQ-032 ssn rise in same cycle as a spi_clk rising edge shall take priority; that edge shall be ignored.
REQ-033 ssn rise before any complete byte (byte_cnt=0, bit count 0) shall give frame_done with no strobes.
REQ-034 spi_clk edges while in IDLE shall be ignored.

Reset
REQ-035 On sys_rst: FSM=IDLE, counters/shift registers=0, address=0, synchronizers=idle level (spi_clk 1, spi_ssn 1, spi_si 0).
REQ-036 Reset output values: spi_so=0, spi_so_oe=0, reg_wr_vld=0, reg_addr=0, reg_wdat=0, reg_rd_req=0, frame_done=0, frame_err=0, byte_cnt=0.
REQ-037 Reset mid-frame shall abort without any strobe; after release, a frame starts only on a new ssn fall.

Verification
REQ-038 Write frame 0x05,0xA1,0xB2 (spi_clk = sys_clk/16) -> reg_wr_vld twice: (addr 0x05,0xA1),(0x06,0xB2); frame_done once; byte_cnt=3.
REQ-039 Read frame 0x85 + 2 dummy bytes, reg_rdat model = addr^0x3C -> master receives 0x39,0x3A; reg_rd_req at 0x05,0x06,0x07.
REQ-040 Write frame 0x7F,0x11,0x22, ADDR_INC=1 -> writes to 0x7F then 0x00; ADDR_INC=0 -> both to 0x7F.
REQ-041 ssn rises after 0x05 plus 3 bits -> frame_err pulse, no reg_wr_vld, byte_cnt=1, spi_so_oe low.
REQ-042 sys_rst asserted after 4 bits of data byte, released, new write 0x10,0x55 -> single write (0x10,0x55), no aborted strobe.
REQ-043 spi_clk toggled 16 times with ssn high -> no strobes, spi_so_oe=0, byte_cnt unchanged.
